// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one 8-bit alu between two valid/ready requesters,
// holding registered operands for EXEC_CYCLES before capturing a held response.
module alu (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] op,
   output logic [7:0] y
);
   logic [2:0] lg;
   logic [3:0] sq;
   always_comb begin
      lg = '0;
      sq = '0;
      for (int i = 0; i < 8; i++) if (a[i]) lg = 3'(i);
      for (int i = 0; i < 16; i++) if (i * i <= int'(a)) sq = 4'(i);
      y = op == 4'b0001 ? a + b :
          op == 4'b0010 ? a - b :
          op == 4'b0100 ? {5'd0, lg} :
          op == 4'b1000 ? {4'd0, sq} : 8'd0;
   end
endmodule

module alu_arbiter #(
   parameter int EXEC_CYCLES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req0_valid_i,
   output logic       req0_ready_o,
   input  logic [7:0] req0_a_i,
   input  logic [7:0] req0_b_i,
   input  logic [3:0] req0_op_i,
   input  logic       req1_valid_i,
   output logic       req1_ready_o,
   input  logic [7:0] req1_a_i,
   input  logic [7:0] req1_b_i,
   input  logic [3:0] req1_op_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic       rsp_id_o,
   output logic [7:0] rsp_y_o,
   output logic       rsp_err_o,
   output logic       busy_o
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state, state_n;
   logic last_grant, id_q, gnt1, accept;
   logic [7:0] a_q, b_q, alu_y;
   logic [3:0] op_q, cnt;

   alu u_alu (.a(a_q), .b(b_q), .op(op_q), .y(alu_y));

   // requester 1 wins alone, or on contention when requester 0 was served last
   assign gnt1 = req1_valid_i & (~req0_valid_i | ~last_grant);
   assign req1_ready_o = rst_ni & (state == IDLE) & gnt1;
   assign req0_ready_o = rst_ni & (state == IDLE) & req0_valid_i & ~gnt1;
   assign accept = req0_ready_o | req1_ready_o;
   assign busy_o = state != IDLE;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state == IDLE ? (accept ? EXEC : IDLE) :
                state == EXEC ? (cnt == 4'd0 ? DONE : EXEC) :
                (rsp_ready_i ? IDLE : DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         id_q <= 1'b0;
         cnt <= '0;
         last_grant <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_id_o <= 1'b0;
         rsp_y_o <= '0;
         rsp_err_o <= 1'b0;
      end else begin
         if (accept) begin
            a_q <= gnt1 ? req1_a_i : req0_a_i;
            b_q <= gnt1 ? req1_b_i : req0_b_i;
            op_q <= gnt1 ? req1_op_i : req0_op_i;
            id_q <= gnt1;
            last_grant <= gnt1;
            cnt <= 4'(EXEC_CYCLES - 1);
         end
         if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (state == EXEC && cnt == 4'd0) begin
            rsp_y_o <= alu_y;
            rsp_err_o <= ~$onehot(op_q);
            rsp_id_o <= id_q;
            rsp_valid_o <= 1'b1;
         end
         if (state == DONE && rsp_ready_i) rsp_valid_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench over three arbiters (EXEC_CYCLES 2, 1, 5) with a
// cycle-level reference of grant order, latency and ALU arithmetic.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic v0[3], v1[3], rr[3], rdy0[3], rdy1[3], rv[3], rid[3], rerr[3], bsy[3];
   logic [7:0] a0[3], b0[3], a1[3], b1[3], ry[3];
   logic [3:0] o0[3], o1[3];

   for (genvar k = 0; k < 3; k++) begin : g_dut
      alu_arbiter #(.EXEC_CYCLES(k == 0 ? 2 : k == 1 ? 1 : 5)) dut (
         .clk_i(clk), .rst_ni(rst_n),
         .req0_valid_i(v0[k]), .req0_ready_o(rdy0[k]), .req0_a_i(a0[k]), .req0_b_i(b0[k]), .req0_op_i(o0[k]),
         .req1_valid_i(v1[k]), .req1_ready_o(rdy1[k]), .req1_a_i(a1[k]), .req1_b_i(b1[k]), .req1_op_i(o1[k]),
         .rsp_valid_o(rv[k]), .rsp_ready_i(rr[k]), .rsp_id_o(rid[k]), .rsp_y_o(ry[k]),
         .rsp_err_o(rerr[k]), .busy_o(bsy[k]));
   end

   typedef struct {int d; logic id; logic [7:0] y; logic err;} exp_t;
   exp_t q[$];
   exp_t pend[3];
   int vectors = 0, miscompares = 0, cyc = 0;
   bit mbusy[3], lg[3];
   int vfrom[3];

   function automatic int exn(input int d);
      return d == 0 ? 2 : d == 1 ? 1 : 5;
   endfunction

   // returns {err, y} from the arithmetic definition of each opcode
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      int r, x;
      case (op)
         4'b0001: return {1'b0, 8'((int'(a) + int'(b)) % 256)};
         4'b0010: return {1'b0, 8'((int'(a) - int'(b) + 256) % 256)};
         4'b0100: begin
            r = 0; x = int'(a);
            while (x > 1) begin x = x / 2; r++; end
            return {1'b0, 8'(r)};
         end
         4'b1000: begin
            r = 0;
            while ((r + 1) * (r + 1) <= int'(a)) r++;
            return {1'b0, 8'(r)};
         end
         default: return {1'b1, 8'd0};
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc_t(input int d, input bit iv0, input logic [7:0] ia0, input logic [7:0] ib0,
                        input logic [3:0] iop0, input bit iv1, input logic [7:0] ia1,
                        input logic [7:0] ib1, input logic [3:0] iop1, input bit irr);
      bit eg0, eg1, evalid;
      logic [8:0] m;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         v0[k] = 0; v1[k] = 0; a0[k] = 0; b0[k] = 0; o0[k] = 0;
         a1[k] = 0; b1[k] = 0; o1[k] = 0; rr[k] = 1;
      end
      v0[d] = iv0; a0[d] = ia0; b0[d] = ib0; o0[d] = iop0;
      v1[d] = iv1; a1[d] = ia1; b1[d] = ib1; o1[d] = iop1; rr[d] = irr;
      #1;
      eg1 = !mbusy[d] && iv1 && (!iv0 || !lg[d]);
      eg0 = !mbusy[d] && iv0 && !eg1;
      evalid = mbusy[d] && cyc >= vfrom[d];
      chk("req0_ready", 8'(rdy0[d]), 8'(eg0));
      chk("req1_ready", 8'(rdy1[d]), 8'(eg1));
      chk("busy", 8'(bsy[d]), 8'(mbusy[d]));
      chk("rsp_valid", 8'(rv[d]), 8'(evalid));
      if (evalid && !irr) begin
         chk("held_y", ry[d], pend[d].y);
         chk("held_id", 8'(rid[d]), 8'(pend[d].id));
         chk("held_err", 8'(rerr[d]), 8'(pend[d].err));
      end
      if (eg0 || eg1) begin
         m = eg1 ? model(ia1, ib1, iop1) : model(ia0, ib0, iop0);
         pend[d] = '{d, eg1, m[7:0], m[8]};
         q.push_back(pend[d]);
         mbusy[d] = 1;
         vfrom[d] = cyc + exn(d) + 1;
         lg[d] = eg1;
      end else if (evalid && irr) mbusy[d] = 0;
      cyc++;
   endtask

   task automatic idle(input int d, input int n);
      repeat (n) cyc_t(d, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         for (int k = 0; k < 3; k++)
            if (rst_n && rv[k] === 1'b1 && rr[k]) begin
               if (q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_rsp: dut %0d id %0d y %0d, none required", k, rid[k], ry[k]);
               end else begin
                  e = q.pop_front();
                  chk("rsp_dut", 8'(k), 8'(e.d));
                  chk("rsp_id", 8'(rid[k]), 8'(e.id));
                  chk("rsp_y", ry[k], e.y);
                  chk("rsp_err", 8'(rerr[k]), 8'(e.err));
               end
            end
      end
   end

   initial begin
      logic [3:0] op;
      rst_n = 0;
      for (int k = 0; k < 3; k++) begin
         v0[k] = 0; v1[k] = 0; a0[k] = 0; b0[k] = 0; o0[k] = 0;
         a1[k] = 0; b1[k] = 0; o1[k] = 0; rr[k] = 1;
         lg[k] = 1; mbusy[k] = 0; vfrom[k] = 0;
      end
      v0[0] = 1; v1[0] = 1;
      #7;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready0", 8'(rdy0[k]), 0);
         chk("rst_ready1", 8'(rdy1[k]), 0);
         chk("rst_valid", 8'(rv[k]), 0);
         chk("rst_busy", 8'(bsy[k]), 0);
         chk("rst_y", ry[k], 0);
         chk("rst_id", 8'(rid[k]), 0);
         chk("rst_err", 8'(rerr[k]), 0);
      end
      #5;
      v0[0] = 0; v1[0] = 0;
      rst_n = 1;
      repeat (12) cyc_t(0, 1, 5, 10, 4'b0010, 1, 144, 8'($urandom), 4'b1000, 1);
      idle(0, 4);
      cyc_t(0, 1, 200, 100, 4'b0001, 0, 0, 0, 0, 1);
      idle(0, 5);
      cyc_t(0, 0, 0, 0, 0, 1, 200, 8'($urandom), 4'b0100, 0);
      repeat (8) cyc_t(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc_t(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc_t(0, 1, 1, 2, 4'b0001, 0, 0, 0, 0, 1);
      idle(0, 4);
      cyc_t(0, 1, 9, 9, 4'b0011, 0, 0, 0, 0, 1);
      idle(0, 4);
      cyc_t(0, 1, 9, 9, 4'b0000, 0, 0, 0, 0, 1);
      idle(0, 4);
      cyc_t(0, 1, 3, 4, 4'b0001, 0, 0, 0, 0, 1);
      idle(0, 4);
      // asynchronous reset pulse lands between edges while the SQRT is executing
      cyc_t(0, 1, 81, 0, 4'b1000, 0, 0, 0, 0, 1);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("midrst_busy", 8'(bsy[0]), 0);
      chk("midrst_valid", 8'(rv[0]), 0);
      chk("midrst_y", ry[0], 0);
      chk("midrst_ready0", 8'(rdy0[0]), 0);
      #1 rst_n = 1;
      for (int k = 0; k < 3; k++) begin lg[k] = 1; mbusy[k] = 0; end
      q.delete();
      cyc_t(0, 1, 7, 1, 4'b0010, 1, 9, 9, 4'b0001, 1);
      idle(0, 6);
      for (int d = 1; d < 3; d++) begin
         cyc_t(d, 1, 200, 100, 4'b0001, 0, 0, 0, 0, 1);
         idle(d, exn(d) + 3);
         cyc_t(d, 0, 0, 0, 0, 1, 255, 0, 4'b1000, 1);
         idle(d, exn(d) + 3);
      end
      for (int d = 0; d < 3; d++) begin
         repeat (80) begin
            op = $urandom_range(0, 9) < 8 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            cyc_t(d, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), op,
                  $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 9) < 8 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom),
                  $urandom_range(0, 2) != 0);
         end
         idle(d, 10);
      end
      chk("queue_empty", 8'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 8-bit `alu` (ADD/SUB/FLOG2/SQRT) between two requesters.
- Uses a round-robin arbiter and valid/ready handshakes on both sides.
- Registers the selected operands and holds them stable for a fixed settle window, because the SQRT/FLOG2 paths are deep combinational logic.
- Presents a registered, held result with requester ID and an illegal-opcode error flag. Sits between the lab top-level control FSMs and the ALU.

Parameters:
- EXEC_CYCLES, 2, cycles operands are held on the ALU before the result is captured; legal range 1..15.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle when high with valid
- req0_a_i  input  8  requester 0 operand A
- req0_b_i  input  8  requester 0 operand B
- req0_op_i  input  4  requester 0 one-hot opcode: 0001 ADD, 0010 SUB, 0100 FLOG2, 1000 SQRT
- req1_valid_i  input  1  requester 1 has an operation
- req1_ready_o  output  1  requester 1 handshake
- req1_a_i  input  8  requester 1 operand A
- req1_b_i  input  8  requester 1 operand B
- req1_op_i  input  4  requester 1 opcode
- rsp_valid_o  output  1  result available
- rsp_ready_i  input  1  consumer accepts result
- rsp_id_o  output  1  requester that issued the result
- rsp_y_o  output  8  ALU result
- rsp_err_o  output  1  opcode was not one of the four legal one-hot codes
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, `rst_ni` low): state=IDLE; `rsp_valid_o`, `rsp_id_o`, `rsp_y_o`, `rsp_err_o`, `busy_o` all 0; both ready outputs 0 during reset; operand registers cleared.
- Reset and round-robin pointer:
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - Reset mid-operation discards the in-flight operation; no response is produced for it.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Grant is combinational from the valids.
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to `last_grant`.
  - `reqN_ready_o` = granted & valid, and only in IDLE. At most one ready is high per cycle; both are 0 outside IDLE.
  - On the handshake edge: latch a, b, op and id; set `last_grant`=id; load counter = EXEC_CYCLES-1; go to EXEC.
- EXEC:
  - Registered operands drive the ALU; `busy_o`=1.
  - If counter==0: capture the ALU output into `rsp_y_o`, set `rsp_err_o`, set `rsp_id_o`=id, set `rsp_valid_o`=1, go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - `rsp_*` outputs are held stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.
  - On `rsp_ready_i`=1: clear `rsp_valid_o` and go to IDLE. The next grant can occur in the following cycle; there is no same-cycle accept.
- Latency:
  - `rsp_valid_o` rises exactly EXEC_CYCLES clock edges after the accept edge.
  - Minimum issue interval is EXEC_CYCLES+2 cycles with `rsp_ready_i` tied high.
- Error handling:
  - `op` not in {0001,0010,0100,1000}, including 0000 and multi-hot codes: `rsp_err_o`=1, `rsp_y_o`=0, and a response is still produced.
  - Legal ops: `rsp_err_o`=0.
- Arithmetic:
  - ADD/SUB wrap modulo 256.
  - FLOG2/SQRT operate on A only; B is ignored.
  - The arbiter does no arithmetic itself; it instantiates `alu` unmodified.
- Requester inputs are sampled only on the handshake edge. Changes while not ready, or after acceptance, have no effect.
- A requester that drops valid before being granted forfeits without affecting `last_grant`.
- `rsp_ready_i` high while `rsp_valid_o`=0 has no effect.
- Counter width is 4 bits.

Test Plan:
- Single request: req0 {a=200, b=100, op=0001}, `rsp_ready_i`=1 → `rsp_valid_o` 2 edges after accept; y=44, id=0, err=0; `busy_o` high for exactly 3 cycles.
- Contention/round-robin: both valid continuously after reset; req0 {5,10,SUB}, req1 {144,x,SQRT} → responses in order id0 y=251, id1 y=12, id0 y=251 again; no grant is ever given while `busy_o`=1.
- Backpressure: req1 {200,x,FLOG2}, hold `rsp_ready_i`=0 for 6 cycles → y=7, id=1 held stable for all 6 cycles; both ready outputs stay 0; IDLE is entered the cycle after `rsp_ready_i` rises.
- Illegal opcode: req0 op=0011, then op=0000 → two responses with err=1, y=0; subsequent legal ADD 3+4 gives y=7, err=0.
- Reset mid-EXEC: accept req0 SQRT 81, pulse `rst_ni` low asynchronously (off-edge) during EXEC → all outputs 0 immediately; no response appears; next contention grants req0 first.
- Parameter sweep: EXEC_CYCLES=1 and 5 → `rsp_valid_o` rises exactly 1 and 5 edges after accept; results match the ALU reference model.
